// File: rtl/share_encoder_2sh_if.sv
// Handshake bundle between the unshared producer, the PRNG and the share-domain
// consumer of the 2-share encoder.
interface share_encoder_2sh_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [N-1:0] rnd;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out1;
  logic [N-1:0] out2;

  // Environment side: supplies the word and the randomness, sinks the shares.
  modport master (
    output in_valid, in_data, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, out1, out2
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, out1, out2
  );
endinterface

// File: rtl/share_encoder_2sh.sv
// Masking front-end: splits an unshared word into share1 = rnd and
// share2 = data ^ rnd using one fresh random word per input. The plaintext is
// held only between input accept and rnd consume; shares are cleared after
// hand-off so nothing stale is visible while out_valid is low.
module share_encoder_2sh #(
  parameter int N  = 64,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  share_encoder_2sh_if.slave  bus,
  output logic [CW-1:0]       mask_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RND = 2'd1,
    OUT      = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  data_q;
  logic [N-1:0]  out1_q;
  logic [N-1:0]  out2_q;
  logic [CW-1:0] mask_cnt_q;
  logic          in_fire;
  logic          rnd_fire;
  logic          out_fire;

  // State register; reset drops any in-flight word by returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept word, wait for randomness, hold shares until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.in_valid)  state_nxt = WAIT_RND;
      WAIT_RND: if (bus.rnd_valid) state_nxt = OUT;
      OUT:      if (bus.out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on same-cycle inputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.rnd_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:     bus.in_ready  = 1'b1;
      WAIT_RND: bus.rnd_ready = 1'b1;
      OUT:      bus.out_valid = 1'b1;
      default:  bus.in_ready  = 1'b0;
    endcase
  end

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign rnd_fire = bus.rnd_valid & bus.rnd_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Datapath: latch word, split with rnd (clearing the plaintext), clear shares after hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      mask_cnt_q <= '0;
    end else begin
      if (in_fire) begin
        data_q <= bus.in_data;
      end
      if (rnd_fire) begin
        out1_q     <= bus.rnd;
        out2_q     <= data_q ^ bus.rnd;
        data_q     <= '0;
        mask_cnt_q <= mask_cnt_q + CW'(1);
      end
      if (out_fire) begin
        out1_q <= '0;
        out2_q <= '0;
      end
    end
  end

  assign bus.out1 = out1_q;
  assign bus.out2 = out2_q;
  assign mask_cnt = mask_cnt_q;

endmodule

// File: tb/tb_share_encoder_2sh.sv
// Bench for share_encoder_2sh: directed steps plus a randomized run checked
// against a queue-based model of accepted words and consumed random words.
module tb_share_encoder_2sh;

  logic        clk;
  logic        rst_n;
  logic [15:0] mask_cnt;
  logic [3:0]  mask_cnt_w;

  share_encoder_2sh_if #(.N(64)) bus ();
  share_encoder_2sh_if #(.N(64)) bus_w ();

  share_encoder_2sh #(.N(64), .CW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mask_cnt (mask_cnt)
  );

  share_encoder_2sh #(.N(64), .CW(4)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_w),
    .mask_cnt (mask_cnt_w)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state (main instance): words in order, rnd words in order.
  logic [63:0] din_q[$];
  logic [63:0] rnd_q[$];
  int n_in  = 0;
  int n_rnd = 0;
  int n_out = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: at each falling edge, check against what the spec rules predict and
  // record the handshakes that will complete on the coming rising edge.
  always @(negedge clk) begin
    int si, sr, so;
    logic [63:0] ed, er;
    if (!rst_n) begin
      din_q.delete();
      rnd_q.delete();
      n_in  = 0;
      n_rnd = 0;
      n_out = 0;
    end else begin
      si = n_in; sr = n_rnd; so = n_out;
      check("mon_mask_cnt", {48'd0, mask_cnt}, 64'(sr % 65536));
      if (!bus.out_valid) begin
        check("mon_idle_out1_zero", bus.out1, 64'd0);
        check("mon_idle_out2_zero", bus.out2, 64'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("mon_out_after_rnd", 64'(sr > so), 64'd1);
        if (din_q.size() > 0 && rnd_q.size() > 0) begin
          ed = din_q.pop_front();
          er = rnd_q.pop_front();
          check("mon_share1_is_rnd", bus.out1, er);
          check("mon_recombine", bus.out1 ^ bus.out2, ed);
        end
        n_out++;
      end
      if (bus.rnd_valid && bus.rnd_ready) begin
        check("mon_rnd_only_pending", 64'(si > sr), 64'd1);
        rnd_q.push_back(bus.rnd);
        n_rnd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        check("mon_in_only_empty", 64'(si == so), 64'd1);
        din_q.push_back(bus.in_data);
        n_in++;
      end
    end
  end

  initial begin
    logic [63:0] d, r;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;   bus.in_data = '0; bus.rnd_valid = 1'b0; bus.rnd = '0; bus.out_ready = 1'b0;
    bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.rnd_valid = 1'b0; bus_w.rnd = '0; bus_w.out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_rnd_ready", 64'(bus.rnd_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out1", bus.out1, 64'd0);
    check("rst_out2", bus.out2, 64'd0);
    check("rst_mask_cnt", {48'd0, mask_cnt}, 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of WAIT_RND with a live plaintext
    bus.in_valid = 1'b1; bus.in_data = 64'hDEAD_BEEF_0000_1111;
    step();
    bus.in_valid = 1'b0;
    check("midrst_in_wait", 64'(bus.rnd_ready), 64'd1);
    bus.rnd_valid = 1'b1; bus.rnd = 64'h5555_AAAA_3333_CCCC;
    rst_n = 1'b0;
    step();
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out1", bus.out1, 64'd0);
    check("midrst_out2", bus.out2, 64'd0);
    check("midrst_mask_cnt", {48'd0, mask_cnt}, 64'd0);
    rst_n = 1'b1;
    step();
    check("postrst_rnd_not_taken", {48'd0, mask_cnt}, 64'd0);
    check("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    bus.rnd_valid = 1'b0;

    // Basic encode with all valids/readies high
    bus.in_valid = 1'b1; bus.in_data = 64'h0123_4567_89AB_CDEF;
    bus.rnd_valid = 1'b1; bus.rnd = 64'hFFFF_0000_FFFF_0000; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("basic_wait_rnd_ready", 64'(bus.rnd_ready), 64'd1);
    check("basic_wait_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("basic_out_valid", 64'(bus.out_valid), 64'd1);
    check("basic_out1", bus.out1, 64'hFFFF_0000_FFFF_0000);
    check("basic_out2", bus.out2, 64'hFEDC_4567_7654_CDEF);
    check("basic_mask_cnt", {48'd0, mask_cnt}, 64'd1);
    step();
    check("basic_out_valid_1cyc", 64'(bus.out_valid), 64'd0);
    check("basic_in_ready_back", 64'(bus.in_ready), 64'd1);
    bus.rnd_valid = 1'b0;

    // PRNG stall with in_valid held high
    d = {$urandom, $urandom}; r = {$urandom, $urandom};
    bus.in_valid = 1'b1; bus.in_data = d;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_rnd_ready", 64'(bus.rnd_ready), 64'd1);
      check("stall_out_valid", 64'(bus.out_valid), 64'd0);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.rnd_valid = 1'b1; bus.rnd = r;
    step();
    bus.in_valid = 1'b0; bus.rnd_valid = 1'b0;
    check("stall_out_valid_after", 64'(bus.out_valid), 64'd1);
    check("stall_out1", bus.out1, r);
    check("stall_out2", bus.out2, d ^ r);
    step();
    check("stall_handoff", 64'(bus.out_valid), 64'd0);

    // Backpressure for 4 cycles
    d = {$urandom, $urandom}; r = {$urandom, $urandom};
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = d;
    bus.rnd_valid = 1'b1; bus.rnd = r;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.rnd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_out1", bus.out1, r);
      check("bp_out2", bus.out2, d ^ r);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_rnd_ready", 64'(bus.rnd_ready), 64'd0);
      check("bp_mask_cnt", {48'd0, mask_cnt}, 64'd3);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_after_out1", bus.out1, 64'd0);
    check("bp_after_out2", bus.out2, 64'd0);
    check("bp_after_valid", 64'(bus.out_valid), 64'd0);

    // Randomized 100-word run from a fresh reset
    rst_n = 1'b0; bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 20000 && n_out < 100; c++) begin
      bus.in_valid  = (n_in < 100) && ($urandom_range(3) != 0);
      bus.in_data   = {$urandom, $urandom};
      bus.rnd_valid = ($urandom_range(2) != 0);
      bus.rnd       = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(2) != 0);
      step();
    end
    bus.in_valid = 1'b0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    check("rand_outputs", 64'(n_out), 64'd100);
    check("rand_inputs", 64'(n_in), 64'd100);
    check("rand_rnd_eq_out", 64'(n_rnd), 64'(n_out));
    check("rand_mask_cnt", {48'd0, mask_cnt}, 64'd100);

    // Counter wrap on the CW=4 instance
    for (int k = 1; k <= 17; k++) begin
      d = {$urandom, $urandom}; r = {$urandom, $urandom};
      bus_w.in_valid = 1'b1; bus_w.in_data = d;
      bus_w.rnd_valid = 1'b1; bus_w.rnd = r; bus_w.out_ready = 1'b1;
      step();
      step();
      check("wrap_out_valid", 64'(bus_w.out_valid), 64'd1);
      check("wrap_recombine", bus_w.out1 ^ bus_w.out2, d);
      check("wrap_mask_cnt", {60'd0, mask_cnt_w}, 64'(k % 16));
      step();
    end
    bus_w.in_valid = 1'b0; bus_w.rnd_valid = 1'b0; bus_w.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/share_encoder_2sh.md
# share_encoder_2sh

Masking front-end for the 2-share threshold PRINCE datapath. It accepts an unshared N-bit word (plaintext or key) over a valid/ready handshake and takes one fresh N-bit random word from the PRNG. It emits a registered 2-share encoding, share 1 = rnd and share 2 = data XOR rnd, to the share-domain XOR/S-box layers. It is the split-side counterpart of the share-wise linear layers, and the only place an unshared word enters the masked core.

## Interface
Parameters:
- N, 64, word width in bits (data, randomness, each share).
- CW, 16, width of the consumed-mask counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  encoder can accept a word.
- in_data  in  N  unshared word.
- rnd_valid  in  1  PRNG word valid.
- rnd_ready  out  1  encoder consumes rnd this cycle when rnd_valid=1.
- rnd  in  N  fresh random word.
- out_valid  out  1  shares valid.
- out_ready  in  1  downstream accepts shares.
- out1  out  N  share 1.
- out2  out  N  share 2.
- mask_cnt  out  CW  count of random words consumed, wraps modulo 2^CW.

## Operation
- FSM states: IDLE, WAIT_RND, OUT. Reset state is IDLE.
- IDLE:
  - in_ready=1, rnd_ready=0, out_valid=0.
  - On in_valid&in_ready: latch in_data into internal data_q and go to WAIT_RND.
- WAIT_RND:
  - rnd_ready=1, in_ready=0.
  - On rnd_valid: out1_q<=rnd, out2_q<=data_q^rnd, data_q<=0, mask_cnt+=1, go to OUT.
  - Otherwise stall indefinitely with data_q held.
- OUT:
  - out_valid=1, in_ready=0, rnd_ready=0.
  - On out_ready: out1_q<=0, out2_q<=0, go to IDLE.
  - Otherwise hold the shares stable.
- Each random word is consumed exactly once. rnd is never sampled outside WAIT_RND, and rnd_ready is never asserted in any other state.
- out1/out2 are driven directly from registers. No combinational path from in_data or rnd to the outputs.
- The plaintext lives only in data_q, and only between input accept and rnd consume. data_q is zero in IDLE and OUT.
- The shares are zeroed after hand-off, so no stale share is visible while out_valid=0.
- mask_cnt wraps from 2^CW-1 to 0 with no flag.
- Reset mid-operation, in any state:
  - state becomes IDLE; data_q, out1, out2, mask_cnt all 0.
  - The in-flight word is dropped.
  - A rnd word presented during reset is not consumed.

## Timing
- Reset values: in_ready=1 (combinational from state IDLE), rnd_ready=0, out_valid=0, out1=0, out2=0, mask_cnt=0.
- Zero-stall latency:
  - Input accepted at edge t.
  - rnd consumed at edge t+1.
  - out_valid=1 from t+1 to t+2.
  - Output handshake at edge t+2.
  - in_ready=1 again in the cycle after t+2.
- Peak throughput: one word per 3 cycles.
- Handshakes:
  - A transfer occurs on a rising edge where valid&ready=1.
  - in_ready, rnd_ready and out_valid depend only on the FSM state, never on same-cycle valid/ready inputs.
  - Upstream may hold in_valid high across cycles; only one word is taken per IDLE visit.
- Simultaneous in_valid and rnd_valid in IDLE: only the input is accepted; rnd is untouched.

## Test plan
- Reset check:
  - Stimulus: assert rst_n=0 mid-WAIT_RND with data_q=64'hDEAD_BEEF_0000_1111.
  - Required: next cycle in_ready=1, out1=out2=0, mask_cnt=0; a later out_valid never shows the dropped word.
- Basic encode:
  - Stimulus: in_data=64'h0123_4567_89AB_CDEF, rnd=64'hFFFF_0000_FFFF_0000, all valids/readies high.
  - Required: out1=64'hFFFF_0000_FFFF_0000, out2=64'hFEDC_4567_7654_CDEF, out_valid exactly 1 cycle, mask_cnt=1.
- PRNG stall:
  - Stimulus: hold rnd_valid=0 for 5 cycles after input accept.
  - Required: rnd_ready=1 throughout, out_valid=0, no second input accepted; shares appear 1 cycle after rnd_valid rises.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles.
  - Required: out1/out2 stable, in_ready=0, rnd_ready=0, mask_cnt unchanged; after hand-off out1=out2=0.
- Randomness usage and recombination:
  - Stimulus: 100 back-to-back words with random data/rnd and random stalls.
  - Required: out1^out2 equals in_data in order, mask_cnt=100, rnd handshakes equal output handshakes.
- Counter wrap:
  - Stimulus: CW=4, run 17 encodes.
  - Required: mask_cnt goes 15 then 0 then 1.
